// File: rtl/mem_pkg.sv
// Shared types and widths for the data memory responder and its storage array.
package mem_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage with byte-enabled synchronous write and registered read.
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    // Contents are deliberately left out of reset so data survives a reset pulse.
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Wait-state data memory slave: captures a request, stalls WAIT_CYCLES, completes in one DONE cycle.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  data_byteenable,
    output logic        data_waitrequest,
    output logic [31:0] data_readdata
);

    state_e              state_d, state_q;
    logic [CNT_W-1:0]    cnt_d, cnt_q;
    logic [ADDR_W-1:0]   addr_d, addr_q;
    logic [DATA_W-1:0]   wdata_d, wdata_q;
    logic [BE_W-1:0]     be_d, be_q;
    logic                op_read_d, op_read_q;
    logic                op_write_d, op_write_q;
    logic                mem_we;
    logic                mem_re;
    logic [DATA_W-1:0]   mem_rdata;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{data_address[31:ADDR_W+2], data_address[1:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        op_read_d  = op_read_q;
        op_write_d = op_write_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_read || data_write) begin
                    addr_d     = data_address[ADDR_W+1:2];
                    wdata_d    = data_writedata;
                    be_d       = data_byteenable;
                    op_write_d = data_write;
                    op_read_d  = data_read && !data_write;
                    cnt_d      = CNT_W'(WAIT_CYCLES);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (!data_read && !data_write) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        mem_re  = op_read_q;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // A reset on this edge must abort the commit, hence the gate.
                mem_we  = op_write_q && !reset;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            op_read_q  <= 1'b0;
            op_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            op_read_q  <= op_read_d;
            op_write_q <= op_write_d;
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (addr_q),
        .be    (be_q),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    assign data_waitrequest = (state_q != DONE);
    assign data_readdata    = (state_q == DONE && op_read_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder with default ADDR_W=10, WAIT_CYCLES=2.
module tb_data_mem_responder;

    localparam int ADDR_W      = 10;
    localparam int WAIT_CYCLES = 2;
    localparam int LATENCY     = WAIT_CYCLES + 1;
    localparam int PERIOD      = WAIT_CYCLES + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [3:0]  data_byteenable;
    logic        data_waitrequest;
    logic [31:0] data_readdata;

    int assert_count = 0;
    int fail_count   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .data_address     (data_address),
        .data_read        (data_read),
        .data_write       (data_write),
        .data_writedata   (data_writedata),
        .data_byteenable  (data_byteenable),
        .data_waitrequest (data_waitrequest),
        .data_readdata    (data_readdata)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be);
        data_read       = rd;
        data_write      = wr;
        data_address    = addr;
        data_writedata  = wdata;
        data_byteenable = be;
    endtask

    // Counts negedges until waitrequest drops (bounded); caller starts right after a negedge.
    task automatic waitDone(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (data_waitrequest && cycles < 20);
    endtask

    task automatic runAccess(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] exp_rdata);
        int cycles;
        applyStimulus(rd, wr, addr, wdata, be);
        waitDone(cycles);
        checkOutput({tag, "_latency"}, 32'(cycles), 32'(LATENCY));
        checkOutput({tag, "_rdata"}, data_readdata, exp_rdata);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput({tag, "_idle_wait"}, 32'(data_waitrequest), 32'd1);
        checkOutput({tag, "_idle_rdata"}, data_readdata, 32'h0);
    endtask

    initial begin
        int cycles;
        int done_seen;

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(negedge clk);
        checkOutput("reset_wait", 32'(data_waitrequest), 32'd1);
        checkOutput("reset_rdata", data_readdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_wait", 32'(data_waitrequest), 32'd1);

        $display("[TB] write then read");
        runAccess("wr_10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0);
        runAccess("rd_10", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF);

        $display("[TB] byte enables");
        runAccess("wr_20_full", 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0);
        runAccess("wr_20_be5", 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0);
        runAccess("rd_20", 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD);
        runAccess("wr_10_be0", 1'b0, 1'b1, 32'h10, 32'h01020304, 4'h0, 32'h0);
        runAccess("rd_10_be0", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF);

        $display("[TB] address wrap and alignment");
        runAccess("wr_1000", 1'b0, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 32'h0);
        runAccess("rd_0003", 1'b1, 1'b0, 32'h0003, 32'h0, 4'h0, 32'hCAFEF00D);

        $display("[TB] dropped request");
        runAccess("wr_40_init", 1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 4'hF, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h40, 32'h55, 4'hF);
        @(negedge clk);
        checkOutput("drop_first_wait", 32'(data_waitrequest), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (!data_waitrequest) done_seen++;
        end
        checkOutput("drop_no_done", 32'(done_seen), 32'd0);
        runAccess("rd_40_drop", 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 32'hA5A5A5A5);

        $display("[TB] reset during DONE");
        runAccess("wr_80_init", 1'b0, 1'b1, 32'h80, 32'h0F0F0F0F, 4'hF, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h80, 32'h12345678, 4'hF);
        waitDone(cycles);
        checkOutput("rst_done_latency", 32'(cycles), 32'(LATENCY));
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("rst_abort_wait", 32'(data_waitrequest), 32'd1);
        checkOutput("rst_abort_rdata", data_readdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        runAccess("rd_80_rst", 1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 32'h0F0F0F0F);

        $display("[TB] simultaneous read and write");
        runAccess("rw_44", 1'b1, 1'b1, 32'h44, 32'h0000BEEF, 4'hF, 32'h0);
        runAccess("rd_44", 1'b1, 1'b0, 32'h44, 32'h0, 4'h0, 32'h0000BEEF);

        $display("[TB] inputs ignored during WAIT and back-to-back throughput");
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h20, 32'hFFFFFFFF, 4'hF);
        waitDone(cycles);
        checkOutput("ignore_latency", 32'(cycles + 1), 32'(LATENCY));
        checkOutput("ignore_rdata", data_readdata, 32'hDEADBEEF);
        waitDone(cycles);
        checkOutput("b2b_period", 32'(cycles), 32'(PERIOD));
        checkOutput("b2b_rdata", data_readdata, 32'h11BB33DD);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("final_idle_wait", 32'(data_waitrequest), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-index width (memory holds 2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, range 1..15, number of wait-state cycles per access.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port data_address  input  32  byte address from the datapath.
REQ-006 SHALL have port data_read  input  1  read request.
REQ-007 SHALL have port data_write  input  1  write request.
REQ-008 SHALL have port data_writedata  input  32  write data.
REQ-009 SHALL have port data_byteenable  input  4  per-byte write enables; bit i gates bits 8i+7:8i.
REQ-010 SHALL have port data_waitrequest  output  1  high while the access is not yet complete.
REQ-011 SHALL have port data_readdata  output  32  read data, valid only in the completion cycle.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-013 IDLE: when data_read or data_write is high, SHALL capture address, writedata, byteenable and op, load counter with WAIT_CYCLES, and go to WAIT.
REQ-014 WAIT: SHALL decrement the counter each cycle; when the counter reaches 1, SHALL go to DONE.
REQ-015 WAIT: if both data_read and data_write are low (request dropped), SHALL go to IDLE and commit nothing.
REQ-016 DONE: SHALL hold for one cycle, then go to IDLE.
REQ-017 data_waitrequest SHALL be low exactly when state is DONE and high otherwise.
REQ-018 Latency: with the request asserted in cycle 0, the completion cycle SHALL be cycle WAIT_CYCLES+1; throughput SHALL be one access per WAIT_CYCLES+2 cycles.
REQ-019 Word index SHALL be captured address bits ADDR_W+1:2; bits 1:0 SHALL be ignored; upper bits SHALL be ignored, so addresses wrap modulo 2^(ADDR_W+2).
REQ-020 Write SHALL commit on the clock edge ending the DONE cycle, updating only bytes whose byteenable bit is high; byteenable 4'b0000 SHALL leave memory unchanged.
REQ-021 Read data SHALL be registered on the last WAIT cycle and presented on data_readdata during DONE; outside DONE data_readdata SHALL be 0.
REQ-022 If read and write are both high at capture, SHALL perform the write only, and data_readdata SHALL be 0 in DONE.
REQ-023 A read issued immediately after a write to the same word SHALL return the newly written data.
REQ-024 Input changes during WAIT or DONE (other than a dropped request) SHALL be ignored; captured values are used.

Reset
REQ-025 Reset SHALL force state IDLE, counter 0, data_waitrequest 1 and data_readdata 0 on the next edge.
REQ-026 Reset during WAIT or DONE SHALL abort the access; no write SHALL commit on that edge.
REQ-027 Reset SHALL NOT clear memory contents.

Structure
REQ-028 Shared package mem_pkg SHALL hold the state enum (IDLE/WAIT/DONE), DATA_W=32 and BE_W=4.
REQ-029 Storage SHALL be a sub-module mem_array: synchronous byte-enabled write, registered read, 2^ADDR_W words.
REQ-030 FSM, counter and capture registers SHALL reside in data_mem_responder.

Verification
REQ-031 Write then read: write 0xDEADBEEF to 0x10, be=4'hF, then read 0x10 -> waitrequest low in cycle 3 (WAIT_CYCLES=2) with readdata 0xDEADBEEF.
REQ-032 Byte enables: word 0x20 = 0x11223344; write 0xAABBCCDD, be=4'b0101 -> subsequent read 0x11BB33DD.
REQ-033 Wrap/alignment (ADDR_W=10): write 0xCAFEF00D to 0x1000, then read 0x0003 -> 0xCAFEF00D.
REQ-034 Dropped request: assert write 0x55 to 0x40, deassert in first WAIT cycle -> state IDLE, no DONE, read 0x40 returns the previous value.
REQ-035 Reset mid-access: reset asserted in the DONE cycle of a write of 0x12345678 to 0x80 -> waitrequest 1, readdata 0, memory at 0x80 unchanged.
REQ-036 Simultaneous read+write to 0x44 with 0x0000BEEF -> readdata 0 in DONE; later read 0x44 returns 0x0000BEEF.
